// File: rtl/turn_input_conditioner.sv
// ============================================================================
// turn_input_conditioner
// ----------------------------------------------------------------------------
// Cleans up the two raw turn push-buttons (KEY2 = right, KEY3 = left) before
// they reach snake_game_fsm. For each key the raw active-low level is
// synchronised into the clock_25 domain, debounced, and turned into a
// single-cycle press event on the released->pressed transition. A small
// pending-request FSM then latches one turn request and holds it until the
// game FSM consumes it with a game_tik strobe. A quick tap between two game
// ticks is therefore never lost, and a key held down produces only one turn.
//
// Optional feature (compile-time macro TURN_AUTOREPEAT_EN):
//   When defined, a key that stays pressed generates a synthetic press every
//   REPEAT_CYCLES cycles. Synthetic presses go through exactly the same
//   pending-request rules as real ones. When the macro is undefined, no
//   repeat logic exists and one physical press yields exactly one event.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a level change is accepted
//   CNT_BIT          debounce counter width, 2**CNT_BIT > DEBOUNCE_CYCLES
//   REPEAT_CYCLES    auto-repeat period in cycles (feature build only)
//
// Ports:
//   clock_25     in   25 MHz system clock
//   reset        in   synchronous reset, active low
//   key_right_n  in   raw KEY2, low = pressed, asynchronous
//   key_left_n   in   raw KEY3, low = pressed, asynchronous
//   game_tik     in   one-cycle consume strobe from game_delay
//   right_P      out  pending right-turn request (level)
//   left_P       out  pending left-turn request (level)
//   key_activity out  one-cycle pulse on any accepted press event
// ============================================================================
module turn_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BIT         = 18,
    parameter int REPEAT_CYCLES   = 6250000
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_right_n,
    input  logic key_left_n,
    input  logic game_tik,
    output logic right_P,
    output logic left_P,
    output logic key_activity
);

    // Terminal count of the debounce counters: a level that has differed for
    // this many consecutive cycles (plus the cycle that matches it) is taken.
    localparam logic [CNT_BIT-1:0] CNT_LAST = CNT_BIT'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_R = 2'd1,
        PEND_L = 2'd2
    } pend_state_t;

    pend_state_t state;
    pend_state_t state_next;

    // Two-flop synchroniser chains
    logic sync_right_1;
    logic sync_right_2;
    logic sync_left_1;
    logic sync_left_2;

    // Debounce counters and accepted (debounced) levels, 1 = released
    logic [CNT_BIT-1:0] cnt_right;
    logic [CNT_BIT-1:0] cnt_left;
    logic               level_right;
    logic               level_left;

    // Previous debounced level, used to find the falling edge
    logic level_right_q;
    logic level_left_q;

    // Physical press events and the final (possibly repeated) press events
    logic edge_right;
    logic edge_left;
    logic press_right;
    logic press_left;

    // ------------------------------------------------------------------------
    // Synchronisers. Both flops reset to 1 so a key held during reset is
    // treated as released until it has been seen through the full chain.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            sync_right_1 <= 1'b1;
            sync_right_2 <= 1'b1;
            sync_left_1  <= 1'b1;
            sync_left_2  <= 1'b1;
        end else begin
            sync_right_1 <= key_right_n;
            sync_right_2 <= sync_right_1;
            sync_left_1  <= key_left_n;
            sync_left_2  <= sync_left_1;
        end
    end

    // ------------------------------------------------------------------------
    // Right key debounce. The counter only runs while the synchronised level
    // disagrees with the accepted one; any agreeing cycle (a glitch back)
    // clears it. The >= compare keeps the counter from ever passing its
    // terminal value, so it cannot wrap even if disturbed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            cnt_right   <= '0;
            level_right <= 1'b1;
        end else if (sync_right_2 == level_right) begin
            cnt_right <= '0;
        end else if (cnt_right >= CNT_LAST) begin
            level_right <= sync_right_2;
            cnt_right   <= '0;
        end else begin
            cnt_right <= cnt_right + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Left key debounce, identical in behaviour to the right key.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            cnt_left   <= '0;
            level_left <= 1'b1;
        end else if (sync_left_2 == level_left) begin
            cnt_left <= '0;
        end else if (cnt_left >= CNT_LAST) begin
            level_left <= sync_left_2;
            cnt_left   <= '0;
        end else begin
            cnt_left <= cnt_left + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection on the debounced levels. Only the 1->0 transition
    // (key going down) is an event; releases are ignored.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            level_right_q <= 1'b1;
            level_left_q  <= 1'b1;
        end else begin
            level_right_q <= level_right;
            level_left_q  <= level_left;
        end
    end

    assign edge_right = level_right_q & ~level_right;
    assign edge_left  = level_left_q  & ~level_left;

`ifdef TURN_AUTOREPEAT_EN
    // ------------------------------------------------------------------------
    // Auto-repeat. Each key has a counter that runs while the key is held.
    // It restarts on any press event of either key, so the first repeat
    // arrives a full period after the real press, and a press of the other
    // key pushes this key's next repeat out by a full period as well.
    // ------------------------------------------------------------------------
    localparam int RPT_BIT = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_BIT-1:0] RPT_LAST = RPT_BIT'(REPEAT_CYCLES - 1);

    logic [RPT_BIT-1:0] rpt_right;
    logic [RPT_BIT-1:0] rpt_left;
    logic               rpt_fire_right;
    logic               rpt_fire_left;

    assign rpt_fire_right = ~level_right & (rpt_right == RPT_LAST);
    assign rpt_fire_left  = ~level_left  & (rpt_left  == RPT_LAST);

    assign press_right = edge_right | rpt_fire_right;
    assign press_left  = edge_left  | rpt_fire_left;

    // Repeat counters: cleared while released and on every press event.
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            rpt_right <= '0;
            rpt_left  <= '0;
        end else begin
            if (level_right || press_right || press_left) begin
                rpt_right <= '0;
            end else begin
                rpt_right <= rpt_right + 1'b1;
            end
            if (level_left || press_left || press_right) begin
                rpt_left <= '0;
            end else begin
                rpt_left <= rpt_left + 1'b1;
            end
        end
    end
`else
    // Without auto-repeat the press events are just the physical edges.
    assign press_right = edge_right;
    assign press_left  = edge_left;

    // The repeat period has no function in this build; it is tied to a
    // deliberately unused net so the parameter remains part of the interface.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // Pending-request state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-request next state. A single press always wins over game_tik:
    // the old request is consumed by the tick while the new one is loaded
    // and waits for the following tick. Presses of both keys in the same
    // cycle are contradictory and are treated as no press at all.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (press_right && !press_left) begin
            state_next = PEND_R;
        end else if (press_left && !press_right) begin
            state_next = PEND_L;
        end else if (game_tik) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs. The request flags are decoded from the next state
    // so they change on the same edge as the state register, and since the
    // state is one-of-three they can never both be high. key_activity
    // reports every press event, including ignored simultaneous ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_25) begin
        if (!reset) begin
            right_P      <= 1'b0;
            left_P       <= 1'b0;
            key_activity <= 1'b0;
        end else begin
            right_P      <= (state_next == PEND_R);
            left_P       <= (state_next == PEND_L);
            key_activity <= press_right | press_left;
        end
    end

endmodule
